// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, absolute jumps, jump-register,
// PC-relative branches and halt, with a one-cycle flush bubble after every redirect.
//
// state  | meaning
// RUN    | fetching; pc_valid=1, one action per unstalled cycle
// BUBBLE | squash slot after a redirect; pc holds, requests ignored
// HALT   | absorbing stop; only rst_n leaves it
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flag,
    input  logic        branch_en,
    input  logic        jump_en,
    input  logic        jr_en,
    input  logic        link,
    input  logic        halt_req,
    input  logic [15:0] offset,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic [31:0] link_pc,
    output logic        halted,
    output logic [15:0] taken_count
);

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_BUBBLE = 2'b01;
    localparam logic [1:0] ST_HALT   = 2'b10;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state;
    logic [1:0]  state_nx;
    logic [31:0] pc_nx;
    logic [31:0] link_nx;
    logic [15:0] count_nx;
    logic        flush_nx;
    logic        valid_nx;
    logic        halted_nx;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;

    assign seq_pc    = pc + STEP;
    assign branch_pc = pc + {{16{offset[15]}}, offset};

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        link_nx  = link_pc;
        count_nx = taken_count;
        flush_nx = 1'b0;
        if (!stall) begin
            case (state)
                ST_RUN: begin
                    // pc_valid=0 while in RUN only right after reset: present RESET_PC first
                    if (!pc_valid) begin
                        pc_nx = pc;
                    end else if (halt_req) begin
                        state_nx = ST_HALT;
                    end else if (jr_en) begin
                        pc_nx    = target;
                        flush_nx = 1'b1;
                        count_nx = taken_count + 16'd1;
                        state_nx = ST_BUBBLE;
                    end else if (jump_en) begin
                        pc_nx    = target;
                        flush_nx = 1'b1;
                        count_nx = taken_count + 16'd1;
                        state_nx = ST_BUBBLE;
                        if (link) begin
                            link_nx = seq_pc;
                        end
                    end else if (branch_en && flag) begin
                        pc_nx    = branch_pc;
                        flush_nx = 1'b1;
                        count_nx = taken_count + 16'd1;
                        state_nx = ST_BUBBLE;
                    end else begin
                        pc_nx = seq_pc;
                    end
                end
                ST_BUBBLE: state_nx = ST_RUN;
                ST_HALT:   state_nx = ST_HALT;
                default:   state_nx = ST_RUN;
            endcase
        end
    end

    // Valid tracks the next state even under stall, so the first edge after
    // reset always raises pc_valid without moving pc.
    assign valid_nx  = (state_nx == ST_RUN);
    assign halted_nx = (state_nx == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            pc_valid    <= 1'b0;
            flush       <= 1'b0;
            link_pc     <= 32'h0000_0000;
            halted      <= 1'b0;
            taken_count <= 16'h0000;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pc_valid    <= valid_nx;
            flush       <= flush_nx;
            link_pc     <= link_nx;
            halted      <= halted_nx;
            taken_count <= count_nx;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues the expected outputs
// for each edge, a monitor pops and compares them just after the edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flag, branch_en, jump_en, jr_en, link, halt_req;
    logic [15:0] offset;
    logic [31:0] target;
    logic [31:0] pc;
    logic        pc_valid, flush, halted;
    logic [31:0] link_pc;
    logic [15:0] taken_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        fl;
        logic        h;
        logic [31:0] lpc;
        logic [15:0] tc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flag(flag),
        .branch_en(branch_en), .jump_en(jump_en), .jr_en(jr_en), .link(link),
        .halt_req(halt_req), .offset(offset), .target(target),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .link_pc(link_pc),
        .halted(halted), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, step_no, act, exp);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("pc", pc, e.pc);
        chk("pc_valid", 32'(pc_valid), 32'(e.v));
        chk("flush", 32'(flush), 32'(e.fl));
        chk("halted", 32'(halted), 32'(e.h));
        chk("link_pc", link_pc, e.lpc);
        chk("taken_count", 32'(taken_count), 32'(e.tc));
    endtask

    // monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                step_no++;
                chk_all(e);
            end
        end
    end

    task automatic idle();
        stall = 0; flag = 0; branch_en = 0; jump_en = 0; jr_en = 0;
        link = 0; halt_req = 0; offset = 16'h0; target = 32'h0;
    endtask

    // inputs already set; queue what must appear after the coming edge
    task automatic cyc(input logic [31:0] epc, input logic ev, input logic efl,
                       input logic eh, input logic [31:0] elpc, input logic [15:0] etc);
        exp_t e;
        e = '{pc: epc, v: ev, fl: efl, h: eh, lpc: elpc, tc: etc};
        q.push_back(e);
        @(negedge clk);
        idle();
    endtask

    task automatic jump(input logic [31:0] t, input logic l);
        jump_en = 1; target = t; link = l;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #3;
        chk_all('{pc: 32'h0, v: 0, fl: 0, h: 0, lpc: 32'h0, tc: 16'h0});
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        // reset release then idle run
        cyc(32'h0, 1, 0, 0, 0, 0);
        cyc(32'h4, 1, 0, 0, 0, 0);
        cyc(32'h8, 1, 0, 0, 0, 0);
        cyc(32'hC, 1, 0, 0, 0, 0);
        jump(32'h100, 0);                      cyc(32'h100, 0, 1, 0, 0, 1);
        cyc(32'h100, 1, 0, 0, 0, 1);
        // taken backward branch
        branch_en = 1; flag = 1; offset = 16'hFFF8;
        cyc(32'hF8, 0, 1, 0, 0, 2);
        cyc(32'hF8, 1, 0, 0, 0, 2);
        cyc(32'hFC, 1, 0, 0, 0, 2);
        // not-taken branch
        jump(32'h40, 0);                       cyc(32'h40, 0, 1, 0, 0, 3);
        cyc(32'h40, 1, 0, 0, 0, 3);
        branch_en = 1; flag = 0; offset = 16'h0010;
        cyc(32'h44, 1, 0, 0, 0, 3);
        // jr wins over jump+link
        jump(32'h20, 0);                       cyc(32'h20, 0, 1, 0, 0, 4);
        cyc(32'h20, 1, 0, 0, 0, 4);
        jr_en = 1; jump(32'h500, 1);           cyc(32'h500, 0, 1, 0, 0, 5);
        cyc(32'h500, 1, 0, 0, 0, 5);
        // jump with link
        jump(32'h20, 0);                       cyc(32'h20, 0, 1, 0, 0, 6);
        cyc(32'h20, 1, 0, 0, 0, 6);
        jump(32'h500, 1);                      cyc(32'h500, 0, 1, 0, 32'h24, 7);
        // stall through the bubble, requests ignored
        stall = 1; branch_en = 1; flag = 1;    cyc(32'h500, 0, 0, 0, 32'h24, 7);
        stall = 1; jump(32'h900, 1);           cyc(32'h500, 0, 0, 0, 32'h24, 7);
        stall = 1;                             cyc(32'h500, 0, 0, 0, 32'h24, 7);
        cyc(32'h500, 1, 0, 0, 32'h24, 7);
        cyc(32'h504, 1, 0, 0, 32'h24, 7);
        // stall in RUN ignores a jump
        stall = 1; jump(32'h999, 1);           cyc(32'h504, 1, 0, 0, 32'h24, 7);
        cyc(32'h508, 1, 0, 0, 32'h24, 7);
        // address wrap both directions
        jump(32'hFFFF_FFFC, 0);                cyc(32'hFFFF_FFFC, 0, 1, 0, 32'h24, 8);
        cyc(32'hFFFF_FFFC, 1, 0, 0, 32'h24, 8);
        cyc(32'h0, 1, 0, 0, 32'h24, 8);
        branch_en = 1; flag = 1; offset = 16'hFFFC;
        cyc(32'hFFFF_FFFC, 0, 1, 0, 32'h24, 9);
        cyc(32'hFFFF_FFFC, 1, 0, 0, 32'h24, 9);
        // halt is absorbing
        jump(32'h80, 0);                       cyc(32'h80, 0, 1, 0, 32'h24, 10);
        cyc(32'h80, 1, 0, 0, 32'h24, 10);
        halt_req = 1; jump(32'h300, 1);        cyc(32'h80, 0, 0, 1, 32'h24, 10);
        branch_en = 1; flag = 1; offset = 16'h0040;
        cyc(32'h80, 0, 0, 1, 32'h24, 10);
        jr_en = 1; jump(32'h300, 1);           cyc(32'h80, 0, 0, 1, 32'h24, 10);
        cyc(32'h80, 0, 0, 1, 32'h24, 10);
        // async reset mid-HALT
        #2 rst_n = 0;
        #1 chk_all('{pc: 32'h0, v: 0, fl: 0, h: 0, lpc: 32'h0, tc: 16'h0});
        @(negedge clk);
        rst_n = 1;
        cyc(32'h0, 1, 0, 0, 0, 0);
        jump(32'h200, 0);                      cyc(32'h200, 0, 1, 0, 0, 1);
        // async reset during the pending flush cycle
        #1 rst_n = 0;
        #1 chk_all('{pc: 32'h0, v: 0, fl: 0, h: 0, lpc: 32'h0, tc: 16'h0});
        @(negedge clk);
        rst_n = 1;
        cyc(32'h0, 1, 0, 0, 0, 0);
        cyc(32'h4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
